bpu_gshare_ras: RTL and testbench
=================================

BPU_GSHARE_RAS -- requirements
Module: bpu_gshare_ras

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 64, BTB entry count, power of 2, >=4.
REQ-002 SHALL have parameter PHT_ENTRIES, default 256, 2-bit counter count, power of 2, >=BTB_ENTRIES.
REQ-003 SHALL have parameter GHR_W, default 8, global history width, <=log2(PHT_ENTRIES).
REQ-004 SHALL have parameter RAS_DEPTH, default 8, return stack depth, power of 2, >=2.
REQ-005 SHALL have parameter RCNT_W, default 3, recursion counter width per RAS slot.
REQ-006 SHALL define META_W = GHR_W + 2*log2(RAS_DEPTH) + 1, holding {ghr_spec, ras_top, ras_num}.
REQ-007 SHALL have ports: clk in 1 clock; reset in 1 asynchronous active-high reset.
REQ-008 SHALL have ports: if_valid in 1 fetch valid; if_pc in 32 fetch PC.
REQ-009 SHALL have ports: pred_taken out 1; pred_target out 32; pred_meta out META_W checkpoint.
REQ-010 SHALL have ports: upd_valid in 1; upd_pc in 32; upd_type in 2 (00 branch, 01 call, 10 return, 11 jump); upd_taken in 1; upd_target in 32; upd_mispredict in 1; upd_meta in META_W.
REQ-011 SHALL have ports: stat_total out 32; stat_correct out 32.

Function
REQ-012 BTB SHALL be direct-mapped: index pc[log2(BTB_ENTRIES)+1:2], tag pc[31:log2(BTB_ENTRIES)+2]; entry = {valid, tag, target, type}.
REQ-013 Prediction SHALL be combinational from if_pc and current state, same cycle.
REQ-014 BTB miss SHALL give pred_taken=0, pred_target=if_pc+4.
REQ-015 Hit, type branch: pred_taken = PHT[idx][1], idx = if_pc[log2(PHT)+1:2] XOR zero-extended ghr_spec; target = BTB target if taken, else if_pc+4.
REQ-016 Hit, type call/jump: pred_taken=1, target = BTB target.
REQ-017 Hit, type return: pred_taken=1; target = RAS top address if ras_num>0, else BTB target.
REQ-018 pred_meta SHALL equal {ghr_spec, ras_top, ras_num} before this fetch's speculative update.
REQ-019 On if_valid & hit, clock edge: branch shifts pred bit into ghr_spec LSB; call speculatively pushes if_pc+4; return speculatively pops.
REQ-020 RAS push: if ras_num>0, top address == pushed value and top rcnt < 2^RCNT_W-1, increment rcnt; else ras_top <= ras_top+1 mod RAS_DEPTH, write address, rcnt=1, ras_num saturating at RAS_DEPTH (oldest overwritten).
REQ-021 RAS pop: ras_num==0 no-op; top rcnt>1 decrement; else ras_top-1 mod RAS_DEPTH, ras_num-1.
REQ-022 On upd_valid: PHT index from upd_pc XOR upd_meta ghr field; counter +1 sat 11 if taken, -1 sat 00 if not, branch type only.
REQ-023 On upd_valid & (upd_taken | type!=branch): BTB entry written {1, tag, upd_target, upd_type}, overwriting any occupant.
REQ-024 On upd_valid & upd_mispredict: ghr_spec <= meta ghr (shifted with upd_taken if branch); ras_top/ras_num <= meta values, then call push / return pop of REQ-020/021 with upd_pc+4; RAS slot contents/rcnt not restored.
REQ-025 Mispredict repair SHALL take priority over any same-cycle fetch speculative update, which is discarded.
REQ-026 Non-mispredict update SHALL not alter ghr_spec or RAS.
REQ-027 upd_valid SHALL increment stat_total; with !upd_mispredict also stat_correct; both wrap mod 2^32.

Reset
REQ-028 reset SHALL asynchronously clear all BTB valid bits, set every PHT counter 01, ghr_spec 0, ras_top 0, ras_num 0, all rcnt 0, stat_total/stat_correct 0.
REQ-029 After reset, outputs SHALL read pred_taken=0, pred_target=if_pc+4, pred_meta=0.
REQ-030 Reset asserted mid-update SHALL discard the update entirely.

Verification
REQ-031 Reset, if_pc=0x80000010 -> pred_taken=0, pred_target=0x80000014, stats 0.
REQ-032 Update branch pc 0x100 taken target 0x80 twice (meta ghr 0) -> PHT 01->10->11; fetch 0x100 with ghr_spec 0 -> pred_taken=1, target 0x80.
REQ-033 Update call pc 0x200 target 0x400 and return pc 0x410 type return; fetch 0x200 then 0x410 -> return predicted to 0x204, ras_num 1->0.
REQ-034 Recursive calls: fetch call 0x200 five times, RCNT_W=3 -> ras_num=1, rcnt=5; five return fetches all predict 0x204, then ras_num=0 and BTB target used.
REQ-035 RAS_DEPTH+1 distinct calls -> ras_num=RAS_DEPTH, oldest lost, ras_top wrapped; RAS_DEPTH returns pop newest-first.
REQ-036 Mispredict with upd_meta ghr 0x0A, branch taken, concurrent fetch of BTB branch -> ghr_spec=0x15 next cycle, fetch update ignored, stat_total+1, stat_correct unchanged.

Source files
------------

// File: rtl/bpu_gshare_ras.sv
// bpu_gshare_ras: gshare direction predictor with direct-mapped BTB and recursion-counting return stack
module bpu_gshare_ras #(
    parameter int BTB_ENTRIES = 64,
    parameter int PHT_ENTRIES = 256,
    parameter int GHR_W = 8,
    parameter int RAS_DEPTH = 8,
    parameter int RCNT_W = 3,
    localparam int BI = $clog2(BTB_ENTRIES),
    localparam int PI = $clog2(PHT_ENTRIES),
    localparam int RI = $clog2(RAS_DEPTH),
    localparam int TW = 30 - BI,
    localparam int META_W = GHR_W + 2 * RI + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [31:0]       if_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    output logic [META_W-1:0] pred_meta,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic [1:0]        upd_type,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_mispredict,
    input  logic [META_W-1:0] upd_meta,
    output logic [31:0]       stat_total,
    output logic [31:0]       stat_correct
);
    localparam logic [RI:0] FULL = (RI + 1)'(RAS_DEPTH);
    localparam logic [RCNT_W-1:0] CMAX = {RCNT_W{1'b1}};

    logic              btb_v [BTB_ENTRIES];
    logic [TW-1:0]     btb_tag [BTB_ENTRIES];
    logic [31:0]       btb_tgt [BTB_ENTRIES];
    logic [1:0]        btb_type [BTB_ENTRIES];
    logic [1:0]        pht [PHT_ENTRIES];
    logic [31:0]       ras_addr [RAS_DEPTH];
    logic [RCNT_W-1:0] ras_cnt [RAS_DEPTH];
    logic [GHR_W-1:0]  ghr;
    logic [RI-1:0]     ras_top;
    logic [RI:0]       ras_num;

    logic [BI-1:0]     bidx, ubidx;
    logic [PI-1:0]     pidx, uidx;
    logic              hit;
    logic [31:0]       seq;
    logic [GHR_W-1:0]  m_ghr, n_ghr;
    logic [RI-1:0]     m_top, b_top, n_top;
    logic [RI:0]       m_num, b_num, n_num;
    logic              repair, spec, push, pop, inc, dec, grow, shrink, wr_en;
    logic [1:0]        op_type;
    logic [31:0]       push_val, t_addr, wr_addr;
    logic [RCNT_W-1:0] t_cnt, wr_cnt;

    assign bidx = if_pc[BI+1:2];
    assign ubidx = upd_pc[BI+1:2];
    assign hit = btb_v[bidx] && btb_tag[bidx] == if_pc[31:BI+2];
    assign pidx = if_pc[PI+1:2] ^ PI'(ghr);
    assign seq = if_pc + 32'd4;
    assign {m_ghr, m_top, m_num} = upd_meta;
    assign uidx = upd_pc[PI+1:2] ^ PI'(m_ghr);
    assign pred_taken = hit && (btb_type[bidx] != 2'b00 || pht[pidx][1]);
    assign pred_target = !pred_taken ? seq :
                         (btb_type[bidx] == 2'b10 && ras_num != '0) ? ras_addr[ras_top] : btb_tgt[bidx];
    assign pred_meta = {ghr, ras_top, ras_num};

    // Next speculative history and RAS: mispredict repair from the checkpoint wins over the fetch
    always_comb begin
        repair = upd_valid && upd_mispredict;
        spec = if_valid && hit;
        b_top = repair ? m_top : ras_top;
        b_num = repair ? m_num : ras_num;
        op_type = repair ? upd_type : btb_type[bidx];
        push = (repair || spec) && op_type == 2'b01;
        pop = (repair || spec) && op_type == 2'b10;
        push_val = repair ? upd_pc + 32'd4 : seq;
        n_ghr = repair ? (upd_type == 2'b00 ? {m_ghr[GHR_W-2:0], upd_taken} : m_ghr) :
                (spec && btb_type[bidx] == 2'b00) ? {ghr[GHR_W-2:0], pred_taken} : ghr;
        t_addr = ras_addr[b_top];
        t_cnt = ras_cnt[b_top];
        inc = push && b_num != '0 && t_addr == push_val && t_cnt != CMAX;
        dec = pop && b_num != '0 && t_cnt > RCNT_W'(1);
        grow = push && !inc;
        shrink = pop && b_num != '0 && !dec;
        n_top = grow ? b_top + RI'(1) : shrink ? b_top - RI'(1) : b_top;
        n_num = grow ? (b_num == FULL ? b_num : b_num + (RI + 1)'(1)) : shrink ? b_num - (RI + 1)'(1) : b_num;
        wr_en = inc || dec || grow;
        wr_addr = dec ? t_addr : push_val;
        wr_cnt = inc ? t_cnt + RCNT_W'(1) : dec ? t_cnt - RCNT_W'(1) : RCNT_W'(1);
    end

    // Resettable state: valid bits, counters, history, stack pointers, statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btb_v[i] <= 1'b0;
            for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= 2'b01;
            for (int i = 0; i < RAS_DEPTH; i++) ras_cnt[i] <= '0;
            ghr <= '0;
            ras_top <= '0;
            ras_num <= '0;
            stat_total <= '0;
            stat_correct <= '0;
        end else begin
            ghr <= n_ghr;
            ras_top <= n_top;
            ras_num <= n_num;
            if (wr_en) ras_cnt[n_top] <= wr_cnt;
            if (upd_valid && upd_type == 2'b00)
                pht[uidx] <= upd_taken ? (pht[uidx] == 2'b11 ? 2'b11 : pht[uidx] + 2'b01) :
                                         (pht[uidx] == 2'b00 ? 2'b00 : pht[uidx] - 2'b01);
            if (upd_valid && (upd_taken || upd_type != 2'b00)) btb_v[ubidx] <= 1'b1;
            if (upd_valid) stat_total <= stat_total + 32'd1;
            if (upd_valid && !upd_mispredict) stat_correct <= stat_correct + 32'd1;
        end
    end

    // Payload storage needs no reset; writes are suppressed while reset is held
    always_ff @(posedge clk) begin
        if (!reset && wr_en) ras_addr[n_top] <= wr_addr;
        if (!reset && upd_valid && (upd_taken || upd_type != 2'b00)) begin
            btb_tag[ubidx] <= upd_pc[31:BI+2];
            btb_tgt[ubidx] <= upd_target;
            btb_type[ubidx] <= upd_type;
        end
    end
endmodule

// File: tb/tb_bpu_gshare_ras.sv
// tb_bpu_gshare_ras: directed checks of BTB, gshare PHT, recursive RAS and mispredict repair
module tb_bpu_gshare_ras;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [14:0] pred_meta;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [1:0]  upd_type;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [14:0] upd_meta;
    logic [31:0] stat_total;
    logic [31:0] stat_correct;
    int total = 0;
    int bad = 0;

    bpu_gshare_ras dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_meta(pred_meta),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_type(upd_type), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict), .upd_meta(upd_meta),
        .stat_total(stat_total), .stat_correct(stat_correct)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [1:0] ty, input logic tk,
                       input logic [31:0] tg, input logic mp, input logic [14:0] meta);
        upd_valid = 1'b1;
        upd_pc = pc;
        upd_type = ty;
        upd_taken = tk;
        upd_target = tg;
        upd_mispredict = mp;
        upd_meta = meta;
        tick();
        upd_valid = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        if_valid = 1'b0;
        if_pc = 32'h8000_0010;
        upd_valid = 1'b0;
        upd_pc = '0;
        upd_type = '0;
        upd_taken = 1'b0;
        upd_target = '0;
        upd_mispredict = 1'b0;
        upd_meta = '0;
        #2;
        chk("rst_taken", pred_taken, 0);
        chk("rst_target", pred_target, 32'h8000_0014);
        chk("rst_meta", pred_meta, 0);
        chk("rst_total", stat_total, 0);
        chk("rst_correct", stat_correct, 0);
        reset = 1'b0;
        tick();
        upd(32'h100, 2'b00, 1'b1, 32'h80, 1'b0, 15'h0);
        if_pc = 32'h100;
        #1;
        chk("br_once_taken", pred_taken, 1);
        upd(32'h100, 2'b00, 1'b1, 32'h80, 1'b0, 15'h0);
        #1;
        chk("br_twice_taken", pred_taken, 1);
        chk("br_twice_target", pred_target, 32'h80);
        chk("br_total", stat_total, 2);
        chk("br_correct", stat_correct, 2);
        upd(32'h200, 2'b01, 1'b1, 32'h400, 1'b0, 15'h0);
        upd(32'h410, 2'b10, 1'b1, 32'h500, 1'b0, 15'h0);
        if_valid = 1'b1;
        if_pc = 32'h200;
        #1;
        chk("call_taken", pred_taken, 1);
        chk("call_target", pred_target, 32'h400);
        chk("call_meta", pred_meta, 15'h0);
        tick();
        if_pc = 32'h410;
        #1;
        chk("ret_target", pred_target, 32'h204);
        chk("ret_meta", pred_meta, 15'h11);
        tick();
        if_valid = 1'b0;
        #1;
        chk("ret_empty_target", pred_target, 32'h500);
        chk("ret_empty_meta", pred_meta, 15'h0);
        if_valid = 1'b1;
        if_pc = 32'h200;
        repeat (5) tick();
        if_valid = 1'b0;
        #1;
        chk("rec_meta", pred_meta, 15'h11);
        for (int k = 0; k < 5; k++) begin
            if_valid = 1'b1;
            if_pc = 32'h410;
            #1;
            chk("rec_ret_target", pred_target, 32'h204);
            chk("rec_ret_meta", pred_meta, 15'h11);
            tick();
        end
        if_valid = 1'b0;
        #1;
        chk("rec_done_target", pred_target, 32'h500);
        chk("rec_done_meta", pred_meta, 15'h0);
        for (int k = 0; k < 9; k++) upd(32'h1020 + 32'(4 * k), 2'b01, 1'b1, 32'h4000, 1'b0, 15'h0);
        for (int k = 0; k < 9; k++) begin
            if_valid = 1'b1;
            if_pc = 32'h1020 + 32'(4 * k);
            tick();
        end
        if_valid = 1'b0;
        #1;
        chk("ovf_meta", pred_meta, 15'h18);
        for (int j = 0; j < 8; j++) begin
            if_valid = 1'b1;
            if_pc = 32'h410;
            #1;
            chk("ovf_ret_target", pred_target, 32'h1024 + 32'(4 * (8 - j)));
            tick();
        end
        if_valid = 1'b0;
        #1;
        chk("ovf_empty_meta", pred_meta, 15'h10);
        chk("ovf_empty_target", pred_target, 32'h500);
        chk("ovf_total", stat_total, 13);
        upd(32'h104, 2'b00, 1'b1, 32'h80, 1'b0, 15'h0);
        if_pc = 32'h104;
        #1;
        chk("br2_taken", pred_taken, 1);
        chk("br2_target", pred_target, 32'h80);
        if_valid = 1'b1;
        upd(32'h600, 2'b00, 1'b1, 32'h700, 1'b1, 15'h500);
        if_valid = 1'b0;
        #1;
        chk("misp_meta", pred_meta, 15'hA80);
        chk("misp_total", stat_total, 15);
        chk("misp_correct", stat_correct, 14);
        upd(32'h2000, 2'b01, 1'b1, 32'h3000, 1'b1, 15'h1D2);
        #1;
        chk("repair_meta", pred_meta, 15'h1E3);
        if_pc = 32'h410;
        #1;
        chk("repair_ret_target", pred_target, 32'h2004);
        chk("repair_total", stat_total, 16);
        chk("repair_correct", stat_correct, 14);
        upd_valid = 1'b1;
        upd_pc = 32'h104;
        upd_type = 2'b00;
        upd_taken = 1'b1;
        upd_target = 32'h80;
        #2;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        upd_valid = 1'b0;
        if_pc = 32'h104;
        #1;
        chk("rst2_total", stat_total, 0);
        chk("rst2_meta", pred_meta, 15'h0);
        chk("rst2_taken", pred_taken, 0);
        chk("rst2_target", pred_target, 32'h108);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
